// File: rtl/dda_trace_pkg.sv
// dda_trace_pkg: shared constants and helpers for the DDA trace buffer.
//   TRACE_DEPTH   - samples held (one per visible VGA column)
//   SAMPLE_W      - sample width, equal to the DDA x_shift width
//   PTR_W         - width of pointers, column indices and the sample count
//   DECIM_DEFAULT - integration steps per stored sample
package dda_trace_pkg;
  localparam int TRACE_DEPTH   = 640;
  localparam int SAMPLE_W      = 9;
  localparam int PTR_W         = 10;
  localparam int DECIM_DEFAULT = 4;

  // Per-query tag carried alongside the RAM read.
  typedef struct packed {
    logic                ok;   // column maps to a stored sample
    logic [SAMPLE_W-1:0] row;  // queried row, compared against the RAM word
  } rd_tag_t;

  // (a + b) mod depth for a, b < depth. The sum is at most 2*depth-2,
  // so one conditional subtract is enough.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] a,
                                                input logic [PTR_W-1:0] b,
                                                input logic [PTR_W:0]   depth);
    logic [PTR_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= depth) s = s - depth;
    return s[PTR_W-1:0];
  endfunction
endpackage

// File: rtl/dda_trace_buffer_ram.sv
// trace_ram: simple dual-port sample store, one write port and one
// registered read port, shaped for block-RAM inference.
//   clk   - clock
//   we    - write enable; waddr/wdata give the write
//   raddr - read address, data appears on rdata the next cycle
// A same-cycle read of the address being written returns the old word.
module trace_ram
  import dda_trace_pkg::*;
#(
  parameter int DEPTH = TRACE_DEPTH,
  parameter int W     = SAMPLE_W,
  parameter int AW    = PTR_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/dda_trace_buffer.sv
// dda_trace_buffer: captures DDA displacement samples into a circular trace
// and answers per-pixel hit queries for a scrolling time plot.
//   clk0_020, rst            - clock, async active-low reset
//   step_en, x_shift         - DDA step strobe and displacement sample
//   freeze, clear            - hold the trace / empty the trace
//   rd_en, rd_col, rd_row    - pixel query (column 0 = oldest sample)
//   rd_valid, pixel_on       - query result, 2 cycles after rd_en
//   full, count              - number of stored samples, saturating at DEPTH
module dda_trace_buffer
  import dda_trace_pkg::*;
#(
  parameter int DEPTH = TRACE_DEPTH,
  parameter int DECIM = DECIM_DEFAULT,
  parameter int Y_W   = SAMPLE_W
) (
  input  logic             clk0_020,
  input  logic             rst,
  input  logic             step_en,
  input  logic [Y_W-1:0]   x_shift,
  input  logic             freeze,
  input  logic             clear,
  input  logic             rd_en,
  input  logic [PTR_W-1:0] rd_col,
  input  logic [Y_W-1:0]   rd_row,
  output logic             rd_valid,
  output logic             pixel_on,
  output logic             full,
  output logic [PTR_W-1:0] count
);
  localparam int DW     = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int STAGES = 2;
  localparam logic [DW-1:0]    DECIM_LAST = DW'(DECIM - 1);
  localparam logic [PTR_W-1:0] DEPTH_P    = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_P     = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W:0]   DEPTH_X    = (PTR_W + 1)'(DEPTH);

  // ---- decimator / write side ----
  logic [DW-1:0]    decim_cnt;
  logic [PTR_W-1:0] wr_ptr, cnt_q;
  logic             advance, wr_fire;

  // clear outranks both the step strobe and freeze
  assign advance = step_en & ~freeze & ~clear;
  assign wr_fire = advance & (decim_cnt == DECIM_LAST);

  always_ff @(posedge clk0_020 or negedge rst) begin
    if (!rst) begin
      decim_cnt <= '0;
      wr_ptr    <= '0;
      cnt_q     <= '0;
    end else if (clear) begin
      decim_cnt <= '0;
      wr_ptr    <= '0;
      cnt_q     <= '0;
    end else if (advance) begin
      if (wr_fire) begin
        decim_cnt <= '0;
        wr_ptr    <= (wr_ptr == LAST_P) ? '0 : wr_ptr + 1'b1;
        if (cnt_q != DEPTH_P) cnt_q <= cnt_q + 1'b1;
      end else begin
        decim_cnt <= decim_cnt + 1'b1;
      end
    end
  end

  assign count = cnt_q;
  assign full  = (cnt_q == DEPTH_P);

  // ---- column -> physical address ----
  // Once full, wr_ptr sits on the oldest sample, so column 0 starts there.
  logic             entry_ok;
  logic [PTR_W-1:0] phys, rd_addr;
  logic [Y_W-1:0]   rd_data;

  assign phys     = full ? wrap_add(wr_ptr, rd_col, DEPTH_X) : rd_col;
  assign entry_ok = (rd_col < DEPTH_P) & (full | (rd_col < cnt_q));
  assign rd_addr  = entry_ok ? phys : '0;  // keep the RAM index in range

  trace_ram #(.DEPTH(DEPTH), .W(Y_W), .AW(PTR_W)) u_ram (
    .clk   (clk0_020),
    .we    (wr_fire),
    .waddr (wr_ptr),
    .wdata (x_shift),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // ---- hit pipeline ----
  logic [STAGES:1] vld_pipe;
  rd_tag_t         tag_q;
  logic            pix_q;

  always_ff @(posedge clk0_020 or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      tag_q    <= '0;
      pix_q    <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], rd_en};
      tag_q    <= '{ok: entry_ok, row: rd_row};
      pix_q    <= vld_pipe[1] & tag_q.ok & (rd_data == tag_q.row);
    end
  end

  assign rd_valid = vld_pipe[STAGES];
  assign pixel_on = pix_q;
endmodule
